// File: rtl/alu_op_sequencer.sv
// Command FIFO and replay sequencer in front of the accumulating ALU register.
// Issues one {Data, Function} per cycle and returns one tagged result per command.
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_data,
  input  logic [2:0] cmd_func,
  input  logic       start,
  output logic [3:0] Data,
  output logic [2:0] Function,
  input  logic [7:0] ALU_reg_out,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_last,
  output logic       done,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          last_pop;
  logic [1:0]    v_pipe;
  logic [1:0]    l_pipe;

  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == RUN) && !empty;
  // Last entry leaves and nothing refills it this cycle
  assign last_pop  = pop && !push && (count == (AW+1)'(1));
  assign busy      = state != IDLE;

  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_data, cmd_func};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      Data      <= '0;
      Function  <= '0;
      op_count  <= '0;
      v_pipe    <= '0;
      l_pipe    <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      done      <= 1'b0;
      res_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);

      if (pop) begin
        {Data, Function} <= mem[rd_ptr];
        op_count         <= op_count + 8'd1;
      end else begin
        Data     <= '0;
        Function <= '0;
      end

      // Result tags ride alongside the ALU pipeline
      v_pipe    <= {v_pipe[0], pop};
      l_pipe    <= {l_pipe[0], last_pop};
      res_valid <= v_pipe[1];
      res_last  <= l_pipe[1];
      done      <= v_pipe[1] && l_pipe[1];
      if (v_pipe[1]) begin
        res_data <= ALU_reg_out;
      end

      unique case (state)
        IDLE: begin
          if (start && !empty) state <= RUN;
        end
        RUN: begin
          if (last_pop || empty) state <= DRAIN;
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural accumulating ALU register.
// Directed vectors, multi-cycle corner sequences and a random scoreboard run.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;

  logic       Clock = 1'b0;
  logic       Reset_b;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic [2:0] cmd_func;
  logic       start;
  logic [3:0] Data;
  logic [2:0] Function;
  logic [7:0] ALU_reg_out;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_last;
  logic       done;
  logic       busy;
  logic [7:0] op_count;

  logic       alu_rst;
  logic [7:0] alu_reg;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .Clock      (Clock),
    .Reset_b    (Reset_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_func   (cmd_func),
    .start      (start),
    .Data       (Data),
    .Function   (Function),
    .ALU_reg_out(ALU_reg_out),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_last   (res_last),
    .done       (done),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] alu_f(
    input logic [7:0] r,
    input logic [3:0] d,
    input logic [2:0] f
  );
    case (f)
      3'd0:    return r + {4'h0, d};
      3'd1:    return r - {4'h0, d};
      3'd2:    return r ^ {4'h0, d};
      3'd3:    return {d, r[3:0]};
      default: return r;
    endcase
  endfunction

  // Behavioural ALU register: updates every clock
  always @(posedge Clock) begin
    if (alu_rst) alu_reg <= 8'h00;
    else         alu_reg <= alu_f(alu_reg, Data, Function);
  end
  assign ALU_reg_out = alu_reg;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [3:0] d, input logic [2:0] f);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_func  = f;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic alu_clear();
    alu_rst = 1'b1;
    tick();
    alu_rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] d0;
    logic [2:0] f0;
    logic [3:0] d1;
    logic [2:0] f1;
    logic [7:0] r0;
    logic [7:0] r1;
  } vec_t;

  vec_t vecs[6];

  // Two-command run from ALU reg 0, start in cycle 0, results in cycles 4 and 5
  task automatic run_pair(input vec_t v);
    alu_clear();
    push_one(v.d0, v.f0);
    push_one(v.d1, v.f1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pair_busy", busy, 1);
    tick();
    chk("pair_data0", {Data, 1'b0, Function}, {v.d0, 1'b0, v.f0});
    tick();
    chk("pair_data1", {Data, 1'b0, Function}, {v.d1, 1'b0, v.f1});
    chk("pair_early", res_valid, 0);
    tick();
    chk("pair_v0", res_valid, 1);
    chk("pair_r0", res_data, v.r0);
    chk("pair_l0", {res_last, done}, 2'b00);
    tick();
    chk("pair_v1", res_valid, 1);
    chk("pair_r1", res_data, v.r1);
    chk("pair_l1", {res_last, done}, 2'b11);
    tick();
    chk("pair_idle", {busy, res_valid}, 2'b00);
  endtask

  // Scoreboard state for the random phase
  logic [7:0] exp_q[$];
  logic [7:0] exp_acc;
  logic       prev_v;
  logic       prev_l;

  task automatic mon();
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        chk("rnd_unexpected", res_data, 32'hFFFF_FFFF);
      end else begin
        chk("rnd_data", res_data, exp_q.pop_front());
      end
    end
    chk("rnd_done", done, res_valid & res_last);
    if (prev_v) chk("rnd_last", prev_l, !res_valid);
    prev_v = res_valid;
    prev_l = res_last;
  endtask

  initial begin
    int seen;
    logic [7:0] last_res;
    int n_acc;

    Reset_b   = 1'b1;
    alu_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_func  = '0;
    start     = 1'b0;
    vecs[0] = '{4'h3, 3'd0, 4'h0, 3'd0, 8'h03, 8'h03};
    vecs[1] = '{4'hF, 3'd0, 4'h1, 3'd0, 8'h0F, 8'h10};
    vecs[2] = '{4'h5, 3'd0, 4'hA, 3'd3, 8'h05, 8'hA5};
    vecs[3] = '{4'hF, 3'd0, 4'hF, 3'd0, 8'h0F, 8'h1E};
    vecs[4] = '{4'h2, 3'd1, 4'h3, 3'd2, 8'hFE, 8'hFD};
    vecs[5] = '{4'h7, 3'd3, 4'h9, 3'd0, 8'h70, 8'h79};
    tick();
    tick();
    Reset_b = 1'b0;
    alu_rst = 1'b0;

    chk("rst_dataf", {Data, 1'b0, Function}, 0);
    chk("rst_res", {res_valid, res_last, done}, 0);
    chk("rst_resdata", res_data, 0);
    chk("rst_opcnt", op_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);

    // Single op: pop in cycle 1, result in cycle 4
    alu_clear();
    push_one(4'h3, 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("one_c1_v", res_valid, 0);
    tick();
    chk("one_c2_data", Data, 4'h3);
    chk("one_c2_v", res_valid, 0);
    tick();
    chk("one_c3_v", res_valid, 0);
    tick();
    chk("one_c4_v", res_valid, 1);
    chk("one_c4_r", res_data, 8'h03);
    chk("one_c4_ld", {res_last, done}, 2'b11);
    chk("one_c4_busy", busy, 1);
    tick();
    chk("one_c5", {busy, res_valid, done}, 0);
    chk("one_opcnt", op_count, 1);

    foreach (vecs[i]) run_pair(vecs[i]);

    // After the concat run, idle no-ops must leave 0xA5 alone
    run_pair(vecs[2]);
    repeat (4) tick();
    chk("idle_keep", alu_reg, 8'hA5);
    chk("idle_noop", {Data, 1'b0, Function}, 0);

    // Ignored start with empty FIFO
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      chk("ign_busy", busy, 0);
      chk("ign_data", Data, 0);
      tick();
    end

    // Full FIFO: fifth push dropped
    alu_clear();
    for (int i = 1; i <= 5; i++) begin
      chk("full_ready", cmd_ready, i <= DEPTH);
      push_one(4'(i), 3'd0);
    end
    chk("full_ready_end", cmd_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    last_res = '0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) begin
        seen++;
        last_res = res_data;
      end
      tick();
    end
    chk("full_count", seen, 4);
    chk("full_lastres", last_res, 8'h0A);
    chk("full_idle", busy, 0);

    // Start during RUN yields no extra results
    alu_clear();
    push_one(4'h1, 3'd0);
    push_one(4'h2, 3'd0);
    push_one(4'h3, 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) seen++;
      tick();
    end
    chk("srun_count", seen, 3);
    chk("srun_idle", busy, 0);

    // Reset held two cycles mid-RUN
    for (int i = 0; i < 4; i++) push_one(4'(i + 1), 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    Reset_b = 1'b1;
    tick();
    chk("mrst_out", {Data, Function, res_valid, res_last, done}, 0);
    chk("mrst_resdata", res_data, 0);
    chk("mrst_opcnt", op_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", cmd_ready, 1);
    tick();
    Reset_b = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_valid) seen++;
      tick();
    end
    chk("mrst_nores", seen, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mrst_empty", busy, 0);

    // Random traffic against the scoreboard
    Reset_b = 1'b1;
    alu_rst = 1'b1;
    tick();
    Reset_b = 1'b0;
    alu_rst = 1'b0;
    exp_acc = 8'h00;
    prev_v = 1'b0;
    prev_l = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 800; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 4'($urandom);
      cmd_func  = 3'($urandom);
      start     = $urandom_range(0, 4) == 0;
      if (cmd_valid && cmd_ready) begin
        exp_acc = alu_f(exp_acc, cmd_data, cmd_func);
        exp_q.push_back(exp_acc);
        n_acc++;
      end
      tick();
      mon();
    end
    cmd_valid = 1'b0;
    seen = 0;
    while ((exp_q.size() != 0 || busy) && seen < 200) begin
      start = 1'b1;
      tick();
      mon();
      seen++;
    end
    start = 1'b0;
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_opcnt", op_count, 8'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
